dcf77_frame_decoder: RTL

//  Next-generation DCF77 receiver front end. Takes the raw demodulator output, then:
//  - synchronises and deglitches it
//  - classifies each second pulse as 0 or 1, with range checks
//  - detects the minute gap and checks frame length and the three parity bits

---
 rtl/dcf77_frame_decoder.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/dcf77_frame_decoder.sv
// DCF77 receiver front end: synchronises and deglitches the demodulator output, classifies
// second pulses and assembles/validates the 59-bit minute frame.
module dcf77_frame_decoder #(
  parameter int unsigned CLOCK_FREQUENCY = 16000000,
  parameter bit          INVERTED        = 1'b0,
  parameter int unsigned FILTER_LEN      = 16,
  parameter int unsigned T_MIN_MS        = 40,
  parameter int unsigned T_SPLIT_MS      = 150,
  parameter int unsigned T_MAX_MS        = 250,
  parameter int unsigned T_MINUTE_MS     = 1500,
  parameter int unsigned T_LOST_MS       = 2500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dcf_in,
  output logic        sec_strobe,
  output logic        bit_strobe,
  output logic        bit_value,
  output logic [5:0]  bit_index,
  output logic        frame_strobe,
  output logic [58:0] frame_bits,
  output logic [2:0]  parity_ok,
  output logic        frame_ok,
  output logic        err_width,
  output logic        err_length,
  output logic        signal_lost
);

  localparam logic [63:0] TMinCyc    = 64'(CLOCK_FREQUENCY) * 64'(T_MIN_MS) / 64'd1000;
  localparam logic [63:0] TSplitCyc  = 64'(CLOCK_FREQUENCY) * 64'(T_SPLIT_MS) / 64'd1000;
  localparam logic [63:0] TMaxCyc    = 64'(CLOCK_FREQUENCY) * 64'(T_MAX_MS) / 64'd1000;
  localparam logic [63:0] TMinuteCyc = 64'(CLOCK_FREQUENCY) * 64'(T_MINUTE_MS) / 64'd1000;
  localparam logic [63:0] TLostCyc   = 64'(CLOCK_FREQUENCY) * 64'(T_LOST_MS) / 64'd1000;

  localparam int unsigned CntW  = $clog2(TLostCyc + 64'd1);
  localparam int unsigned FiltW = $clog2(FILTER_LEN + 1);

  localparam logic [CntW-1:0]  TMin    = CntW'(TMinCyc);
  localparam logic [CntW-1:0]  TSplit  = CntW'(TSplitCyc);
  localparam logic [CntW-1:0]  TMax    = CntW'(TMaxCyc);
  localparam logic [CntW-1:0]  TMinute = CntW'(TMinuteCyc);
  localparam logic [CntW-1:0]  TLost   = CntW'(TLostCyc);
  localparam logic [FiltW-1:0] FiltTop = FiltW'(FILTER_LEN - 1);
  localparam logic [5:0]       LastIdx = 6'd59;

  logic             sync1_q, sync1_d, sync2_q, sync2_d;
  logic             filt_q, filt_d, filt_prev_q, filt_prev_d;
  logic [FiltW-1:0] fcnt_q, fcnt_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             synced_q, synced_d, seen_rise_q, seen_rise_d;
  logic             frame_bad_q, frame_bad_d;
  logic [5:0]       bit_index_q, bit_index_d;
  logic [58:0]      data_q, data_d;
  logic             sec_strobe_q, sec_strobe_d, bit_strobe_q, bit_strobe_d;
  logic             bit_value_q, bit_value_d, frame_strobe_q, frame_strobe_d;
  logic [58:0]      frame_bits_q, frame_bits_d;
  logic [2:0]       parity_ok_q, parity_ok_d;
  logic             frame_ok_q, frame_ok_d;
  logic             err_width_q, err_width_d, err_length_q, err_length_d;
  logic             signal_lost_q, signal_lost_d;

  logic       sample, rise, fall, width_bit;
  logic [2:0] par;

  // Filtered level is 1 while the carrier is reduced.
  assign sample = sync2_q ^ INVERTED;
  assign rise   = filt_q & ~filt_prev_q;
  assign fall   = ~filt_q & filt_prev_q;
  assign width_bit = (cnt_q >= TSplit);
  // Even parity including the parity bit itself.
  assign par = {~^data_q[58:36], ~^data_q[35:29], ~^data_q[28:21]};

  always_comb begin
    sync1_d        = dcf_in;
    sync2_d        = sync1_q;
    filt_d         = filt_q;
    fcnt_d         = fcnt_q;
    filt_prev_d    = filt_q;
    cnt_d          = (cnt_q == TLost) ? cnt_q : cnt_q + CntW'(1);
    synced_d       = synced_q;
    seen_rise_d    = seen_rise_q;
    frame_bad_d    = frame_bad_q;
    bit_index_d    = bit_index_q;
    data_d         = data_q;
    sec_strobe_d   = 1'b0;
    bit_strobe_d   = 1'b0;
    bit_value_d    = bit_value_q;
    frame_strobe_d = 1'b0;
    frame_bits_d   = frame_bits_q;
    parity_ok_d    = parity_ok_q;
    frame_ok_d     = frame_ok_q;
    err_width_d    = 1'b0;
    err_length_d   = 1'b0;
    signal_lost_d  = signal_lost_q;

    if (sample == filt_q) begin
      fcnt_d = '0;
    end else if (fcnt_q == FiltTop) begin
      filt_d = ~filt_q;
      fcnt_d = '0;
    end else begin
      fcnt_d = fcnt_q + FiltW'(1);
    end

    if (rise) begin
      cnt_d         = '0;
      sec_strobe_d  = 1'b1;
      signal_lost_d = 1'b0;
      seen_rise_d   = 1'b1;
      if (cnt_q >= TMinute) begin
        // The first marker after reset or loss only establishes frame alignment.
        if (synced_q) begin
          if (bit_index_q == LastIdx && !frame_bad_q) begin
            frame_bits_d   = data_q;
            parity_ok_d    = par;
            frame_ok_d     = (&par) & data_q[20];
            frame_strobe_d = 1'b1;
          end else if (bit_index_q != LastIdx) begin
            err_length_d = 1'b1;
          end
        end
        synced_d    = 1'b1;
        bit_index_d = '0;
        frame_bad_d = 1'b0;
      end
    end else if (fall && seen_rise_q) begin
      if (cnt_q < TMin || cnt_q > TMax) begin
        err_width_d = 1'b1;
        frame_bad_d = 1'b1;
      end else begin
        bit_strobe_d = 1'b1;
        bit_value_d  = width_bit;
        if (bit_index_q < LastIdx) begin
          data_d[bit_index_q] = width_bit;
          bit_index_d         = bit_index_q + 6'd1;
        end else begin
          frame_bad_d = 1'b1;
        end
      end
    end

    if (!rise && cnt_q == TLost) begin
      signal_lost_d = 1'b1;
      bit_index_d   = '0;
      frame_bad_d   = 1'b1;
      synced_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q        <= 1'b0;
      sync2_q        <= 1'b0;
      filt_q         <= 1'b0;
      fcnt_q         <= '0;
      filt_prev_q    <= 1'b0;
      cnt_q          <= '0;
      synced_q       <= 1'b0;
      seen_rise_q    <= 1'b0;
      frame_bad_q    <= 1'b0;
      bit_index_q    <= '0;
      data_q         <= '0;
      sec_strobe_q   <= 1'b0;
      bit_strobe_q   <= 1'b0;
      bit_value_q    <= 1'b0;
      frame_strobe_q <= 1'b0;
      frame_bits_q   <= '0;
      parity_ok_q    <= '0;
      frame_ok_q     <= 1'b0;
      err_width_q    <= 1'b0;
      err_length_q   <= 1'b0;
      signal_lost_q  <= 1'b1;
    end else begin
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      filt_q         <= filt_d;
      fcnt_q         <= fcnt_d;
      filt_prev_q    <= filt_prev_d;
      cnt_q          <= cnt_d;
      synced_q       <= synced_d;
      seen_rise_q    <= seen_rise_d;
      frame_bad_q    <= frame_bad_d;
      bit_index_q    <= bit_index_d;
      data_q         <= data_d;
      sec_strobe_q   <= sec_strobe_d;
      bit_strobe_q   <= bit_strobe_d;
      bit_value_q    <= bit_value_d;
      frame_strobe_q <= frame_strobe_d;
      frame_bits_q   <= frame_bits_d;
      parity_ok_q    <= parity_ok_d;
      frame_ok_q     <= frame_ok_d;
      err_width_q    <= err_width_d;
      err_length_q   <= err_length_d;
      signal_lost_q  <= signal_lost_d;
    end
  end

  assign sec_strobe   = sec_strobe_q;
  assign bit_strobe   = bit_strobe_q;
  assign bit_value    = bit_value_q;
  assign bit_index    = bit_index_q;
  assign frame_strobe = frame_strobe_q;
  assign frame_bits   = frame_bits_q;
  assign parity_ok    = parity_ok_q;
  assign frame_ok     = frame_ok_q;
  assign err_width    = err_width_q;
  assign err_length   = err_length_q;
  assign signal_lost  = signal_lost_q;

endmodule
